// File: rtl/prg_saver.sv
// prg_saver: streams the resident BASIC program out of PET RAM as a .PRG byte stream,
// a 2-byte little-endian load address followed by RAM[start .. end-1], ioctl-upload style.
module prg_saver #(
    parameter int unsigned RD_LAT   = 1,
    parameter logic [15:0] PTR_BASE = 16'h0028,
    parameter logic [15:0] MAX_ADDR = 16'h8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    input  logic [7:0]  dma_din,
    output logic [24:0] out_addr,
    output logic [7:0]  out_data,
    output logic        out_wr,
    input  logic        out_wait,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [24:0] length
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_PTR  = 4'd1;
    localparam logic [3:0] S_CHK  = 4'd2;
    localparam logic [3:0] S_HDR0 = 4'd3;
    localparam logic [3:0] S_HDR1 = 4'd4;
    localparam logic [3:0] S_MRD  = 4'd5;
    localparam logic [3:0] S_MWT  = 4'd6;
    localparam logic [3:0] S_EMIT = 4'd7;
    localparam logic [3:0] S_FIN  = 4'd8;

    localparam logic [7:0] LAT_INIT = 8'(RD_LAT);

    logic [3:0]  state;
    logic [1:0]  ptr_idx;
    logic        rd_pend;
    logic [7:0]  lat_cnt;
    logic [15:0] start_ptr;
    logic [15:0] end_ptr;
    logic [15:0] ptr;
    logic [15:0] cnt;

    // Strobes default low each cycle; a state raises them for exactly one cycle.
    // Emit states strobe one cycle after seeing out_wait low and leave on the strobe cycle,
    // so a late out_wait rise never cancels a strobe already on the wire.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr_idx   <= '0;
            rd_pend   <= 1'b0;
            lat_cnt   <= '0;
            start_ptr <= '0;
            end_ptr   <= '0;
            ptr       <= '0;
            cnt       <= '0;
            dma_addr  <= '0;
            dma_rd    <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_wr    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            length    <= '0;
        end else begin
            dma_rd <= 1'b0;
            out_wr <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !done && !error) begin
                        state   <= S_PTR;
                        busy    <= 1'b1;
                        ptr_idx <= '0;
                        rd_pend <= 1'b0;
                        length  <= '0;
                    end
                end
                S_PTR: begin
                    if (!rd_pend) begin
                        dma_addr <= PTR_BASE + 16'(ptr_idx);
                        dma_rd   <= 1'b1;
                        rd_pend  <= 1'b1;
                        lat_cnt  <= LAT_INIT;
                    end else if (lat_cnt != 8'd0) begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end else begin
                        rd_pend <= 1'b0;
                        case (ptr_idx)
                            2'd0: start_ptr[7:0]  <= dma_din;
                            2'd1: start_ptr[15:8] <= dma_din;
                            2'd2: end_ptr[7:0]    <= dma_din;
                            2'd3: end_ptr[15:8]   <= dma_din;
                        endcase
                        ptr_idx <= ptr_idx + 2'd1;
                        if (ptr_idx == 2'd3) begin
                            state <= S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (end_ptr < start_ptr || end_ptr > MAX_ADDR) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt      <= end_ptr - start_ptr;
                        ptr      <= start_ptr;
                        out_addr <= '0;
                        out_data <= start_ptr[7:0];
                        state    <= S_HDR0;
                    end
                end
                S_HDR0: begin
                    if (out_wr) begin
                        out_addr <= 25'd1;
                        out_data <= start_ptr[15:8];
                        state    <= S_HDR1;
                    end else if (!out_wait) begin
                        out_wr <= 1'b1;
                    end
                end
                S_HDR1: begin
                    if (out_wr) begin
                        state <= S_MRD;
                    end else if (!out_wait) begin
                        out_wr <= 1'b1;
                    end
                end
                S_MRD: begin
                    if (cnt == 16'd0) begin
                        state <= S_FIN;
                    end else begin
                        dma_addr <= ptr;
                        dma_rd   <= 1'b1;
                        lat_cnt  <= LAT_INIT;
                        state    <= S_MWT;
                    end
                end
                S_MWT: begin
                    if (lat_cnt != 8'd0) begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end else begin
                        out_data <= dma_din;
                        out_addr <= 25'(ptr - start_ptr) + 25'd2;
                        state    <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_wr) begin
                        ptr   <= ptr + 16'd1;
                        cnt   <= cnt - 16'd1;
                        state <= S_MRD;
                    end else if (!out_wait) begin
                        out_wr <= 1'b1;
                    end
                end
                S_FIN: begin
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    length <= 25'(end_ptr - start_ptr) + 25'd2;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prg_saver.sv
// Bench for prg_saver: two instances (RD_LAT 1 and 2) share a RAM model; each save is compared
// against a stream computed from the pointer rules and the RAM contents.
module tb_prg_saver;

    logic        clk = 1'b0;
    logic        reset;
    logic        out_wait;
    logic        start_s    [2];
    logic [15:0] dma_addr_s [2];
    logic        dma_rd_s   [2];
    logic [7:0]  dma_din_s  [2];
    logic [24:0] out_addr_s [2];
    logic [7:0]  out_data_s [2];
    logic        out_wr_s   [2];
    logic        busy_s     [2];
    logic        done_s     [2];
    logic        error_s    [2];
    logic [24:0] length_s   [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        prg_saver #(.RD_LAT(g + 1)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start_s[g]),
            .dma_addr (dma_addr_s[g]),
            .dma_rd   (dma_rd_s[g]),
            .dma_din  (dma_din_s[g]),
            .out_addr (out_addr_s[g]),
            .out_data (out_data_s[g]),
            .out_wr   (out_wr_s[g]),
            .out_wait (out_wait),
            .busy     (busy_s[g]),
            .done     (done_s[g]),
            .error    (error_s[g]),
            .length   (length_s[g])
        );
    end

    // RAM with 1- and 2-cycle read pipelines; outside the valid cycle the data bus carries junk.
    logic [7:0] ram [0:65535];
    logic       v0, v1a, v1b;
    logic [7:0] d0, d1a, d1b, junk;
    always @(posedge clk) begin
        v0   <= dma_rd_s[0];
        d0   <= ram[dma_addr_s[0]];
        v1a  <= dma_rd_s[1];
        d1a  <= ram[dma_addr_s[1]];
        v1b  <= v1a;
        d1b  <= d1a;
        junk <= 8'($urandom);
    end
    assign dma_din_s[0] = v0  ? d0  : junk;
    assign dma_din_s[1] = v1b ? d1b : junk;

    int          n_tests = 0;
    int          n_fail  = 0;
    string       tname;
    logic [7:0]  exp_b [$];
    logic [15:0] exp_r [$];
    bit          exp_err;
    int          exp_len;
    logic [24:0] wa [$];
    logic [7:0]  wd [$];
    logic [15:0] rds [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", tname, tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs(input int s);
        return {10'd0, dma_addr_s[s], dma_rd_s[s], out_addr_s[s], out_data_s[s],
                out_wr_s[s], busy_s[s], done_s[s], error_s[s]};
    endfunction

    task automatic set_ptrs(input logic [15:0] sp, input logic [15:0] ep);
        ram[16'h0028] = sp[7:0];
        ram[16'h0029] = sp[15:8];
        ram[16'h002A] = ep[7:0];
        ram[16'h002B] = ep[15:8];
    endtask

    // Reference: the file is load address + RAM[start..end-1]; bad pointers give nothing.
    task automatic build_exp();
        logic [15:0] sp, ep;
        sp = {ram[16'h0029], ram[16'h0028]};
        ep = {ram[16'h002B], ram[16'h002A]};
        exp_b.delete();
        exp_r.delete();
        for (int i = 0; i < 4; i++) exp_r.push_back(16'(16'h0028 + i));
        exp_err = (ep < sp) || (ep > 16'h8000);
        exp_len = 0;
        if (!exp_err) begin
            exp_b.push_back(sp[7:0]);
            exp_b.push_back(sp[15:8]);
            for (int a = int'(sp); a < int'(ep); a++) begin
                exp_b.push_back(ram[a]);
                exp_r.push_back(16'(a));
            end
            exp_len = int'(ep) - int'(sp) + 2;
        end
    endtask

    // mode 0: no backpressure, 1: 3-cycle waits before bytes 2 and 5, 2: random out_wait.
    // poke: extra start pulses while busy and in the done/error cycle. abort_at: reset after that strobe.
    task automatic run_save(input int s, input int mode, input bit poke, input int abort_at);
        int          wl = 0;
        bit          fin = 0;
        int          ndone = 0, nerr = 0, both = 0, wviol = 0, pviol = 0;
        logic [24:0] len = '0;
        build_exp();
        wa.delete();
        wd.delete();
        rds.delete();
        @(negedge clk);
        start_s[s] = 1'b1;
        @(negedge clk);
        start_s[s] = 1'b0;
        chk("busy_start", 64'(busy_s[s]), 64'd1);
        for (int c = 0; c < 2000 && !fin; c++) begin
            if (dma_rd_s[s]) rds.push_back(dma_addr_s[s]);
            if (dma_rd_s[s] && out_wr_s[s]) both++;
            if (out_wr_s[s]) begin
                if (out_wait) wviol++;
                wa.push_back(out_addr_s[s]);
                wd.push_back(out_data_s[s]);
            end else if (out_wait && wa.size() > 0 && wa.size() < exp_b.size()
                         && out_addr_s[s] == 25'(wa.size())
                         && out_data_s[s] !== exp_b[wa.size()]) begin
                pviol++;
            end
            if (done_s[s]) begin
                fin = 1;
                ndone++;
                len = length_s[s];
            end
            if (error_s[s]) begin
                fin = 1;
                nerr++;
            end
            if (abort_at > 0 && out_wr_s[s] && wa.size() == abort_at) begin
                reset    = 1'b1;
                out_wait = 1'b0;
                @(negedge clk);
                chk("abort_outs", outs(s), 64'd0);
                chk("abort_len", 64'(length_s[s]), 64'd0);
                chk("abort_nodone", 64'(ndone), 64'd0);
                reset = 1'b0;
                return;
            end
            start_s[s] = fin ? poke : (poke && c == 6);
            if (mode == 1) begin
                if (out_wr_s[s] && (wa.size() == 1 || wa.size() == 4)) wl = 3;
                out_wait = (wl > 0);
                if (wl > 0) wl--;
            end else if (mode == 2) begin
                out_wait = ($urandom_range(0, 3) == 0);
            end else begin
                out_wait = 1'b0;
            end
            @(negedge clk);
        end
        start_s[s] = 1'b0;
        out_wait   = 1'b0;
        chk("timeout", 64'(!fin), 64'd0);
        chk("busy_after", 64'(busy_s[s]), 64'd0);
        chk("pulse_1cyc", 64'({done_s[s], error_s[s]}), 64'd0);
        chk("done_cnt", 64'(ndone), exp_err ? 64'd0 : 64'd1);
        chk("error_cnt", 64'(nerr), exp_err ? 64'd1 : 64'd0);
        if (!exp_err) chk("length", 64'(len), 64'(exp_len));
        chk("overlap", 64'(both), 64'd0);
        chk("wr_in_wait", 64'(wviol), 64'd0);
        chk("held_data", 64'(pviol), 64'd0);
        chk("n_bytes", 64'(wd.size()), 64'(exp_b.size()));
        for (int i = 0; i < wd.size() && i < exp_b.size(); i++) begin
            chk($sformatf("byte%0d", i), 64'(wd[i]), 64'(exp_b[i]));
            chk($sformatf("addr%0d", i), 64'(wa[i]), 64'(i));
        end
        chk("n_reads", 64'(rds.size()), 64'(exp_r.size()));
        for (int i = 0; i < rds.size() && i < exp_r.size(); i++) begin
            chk($sformatf("rd%0d", i), 64'(rds[i]), 64'(exp_r[i]));
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sp, ep;
        int          kind;
        reset      = 1'b1;
        out_wait   = 1'b0;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        repeat (3) @(negedge clk);
        tname = "reset";
        chk("outs0", outs(0), 64'd0);
        chk("len0", 64'(length_s[0]), 64'd0);
        chk("outs1", outs(1), 64'd0);
        reset = 1'b0;

        ram[16'h0401] = 8'hAA;
        ram[16'h0402] = 8'hBB;
        ram[16'h0403] = 8'hCC;
        ram[16'h0404] = 8'hDD;
        ram[16'h0405] = 8'hEE;
        set_ptrs(16'h0401, 16'h0406);
        tname = "basic";
        run_save(0, 0, 1'b0, 0);
        tname = "backpressure";
        run_save(0, 1, 1'b0, 0);

        tname = "empty";
        set_ptrs(16'h0401, 16'h0401);
        run_save(0, 0, 1'b1, 0);

        tname = "end_lt_start";
        set_ptrs(16'h0500, 16'h0400);
        run_save(0, 0, 1'b1, 0);
        tname = "end_gt_max";
        set_ptrs(16'h0401, 16'h8001);
        run_save(0, 0, 1'b0, 0);

        tname = "abort";
        set_ptrs(16'h0401, 16'h0406);
        run_save(0, 0, 1'b0, 4);
        tname = "after_abort";
        run_save(0, 0, 1'b0, 0);

        tname = "top_lat2";
        ram[16'h7FFE] = 8'($urandom);
        ram[16'h7FFF] = 8'($urandom);
        set_ptrs(16'h7FFE, 16'h8000);
        run_save(1, 0, 1'b0, 0);

        for (int k = 0; k < 16; k++) begin
            kind = $urandom_range(0, 5);
            sp   = 16'($urandom_range(16'h0400, 16'h7F00));
            case (kind)
                0:       ep = sp - 16'($urandom_range(1, 50));
                1:       ep = 16'h8000 + 16'($urandom_range(1, 200));
                2: begin
                    sp = 16'h8000 - 16'($urandom_range(0, 12));
                    ep = 16'h8000;
                end
                default: ep = sp + 16'($urandom_range(0, 24));
            endcase
            for (int a = int'(sp); a < int'(sp) + 40; a++) ram[16'(a)] = 8'($urandom);
            set_ptrs(sp, ep);
            tname = $sformatf("rand%0d", k);
            run_save(k % 2, 2, 1'(k / 2), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
